// File: rtl/snn_spike_serializer.sv
// snn_spike_serializer: parallel spike vector to valid/ready serial stream with optional bias slot, one-deep pending buffer, frame markers, timestep counter and sticky overflow; ports: clk, reset (async, active-high), spk_vec_valid/spk_vec capture input, out_valid/out_ready/out_spk/out_idx/out_first/out_last serial output, frame_done, step_idx, busy, overflow, clr_overflow
module snn_spike_serializer #(
  parameter int N_IN    = 20,
  parameter int BIAS_EN = 1,
  parameter int T_STEPS = 8,
  parameter int IDX_W   = $clog2(N_IN + 1),
  parameter int STEP_W  = (T_STEPS > 1) ? $clog2(T_STEPS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spk_vec_valid,
  input  logic [N_IN-1:0]   spk_vec,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_spk,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_first,
  output logic              out_last,
  output logic              frame_done,
  output logic [STEP_W-1:0] step_idx,
  output logic              busy,
  output logic              overflow,
  input  logic              clr_overflow
);
  localparam int L = N_IN - 1 + BIAS_EN;
  typedef enum logic {IDLE, STREAM} state_t;
  state_t state, state_n;
  logic pend_full, pend_full_n, xfer, last, ovf_n;
  logic [N_IN-1:0] act, act_n, pend, pend_n;
  logic [N_IN:0] slots;
  logic [IDX_W-1:0] idx_n;
  logic [STEP_W-1:0] step_n;
  always_comb begin
    xfer = out_valid & out_ready;
    last = xfer & (out_idx == IDX_W'(L));
    state_n = state;
    pend_full_n = pend_full;
    act_n = act;
    pend_n = pend;
    ovf_n = overflow & ~clr_overflow;
    idx_n = xfer ? out_idx + 1'b1 : out_idx;
    step_n = step_idx;
    if (last) begin
      idx_n = '0;
      step_n = (step_idx == STEP_W'(T_STEPS - 1)) ? '0 : step_idx + 1'b1;
      state_n = pend_full ? STREAM : IDLE;
      act_n = pend_full ? pend : act;
      pend_full_n = 1'b0;
    end
    // capture is resolved after promotion, so a freed slot is reusable in the same cycle
    if (spk_vec_valid) begin
      if (state_n == IDLE) begin
        state_n = STREAM;
        act_n = spk_vec;
        idx_n = '0;
      end else if (!pend_full_n) begin
        pend_full_n = 1'b1;
        pend_n = spk_vec;
      end else begin
        ovf_n = 1'b1;
      end
    end
    // bit N_IN is the constant-1 bias slot
    slots = {1'b1, act_n};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pend_full <= 1'b0;
      act <= '0;
      pend <= '0;
      out_valid <= 1'b0;
      out_spk <= 1'b0;
      out_idx <= '0;
      out_first <= 1'b0;
      out_last <= 1'b0;
      frame_done <= 1'b0;
      step_idx <= '0;
      busy <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      pend_full <= pend_full_n;
      act <= act_n;
      pend <= pend_n;
      out_valid <= state_n == STREAM;
      out_spk <= (state_n == STREAM) & slots[idx_n];
      out_idx <= idx_n;
      out_first <= (state_n == STREAM) & (idx_n == '0);
      out_last <= (state_n == STREAM) & (idx_n == IDX_W'(L));
      frame_done <= last;
      step_idx <= step_n;
      busy <= (state_n == STREAM) | pend_full_n;
      overflow <= ovf_n;
    end
  end
endmodule

// File: tb/tb_snn_spike_serializer.sv
// tb_snn_spike_serializer: randomized scoreboard bench for snn_spike_serializer
module tb_snn_spike_serializer;
  localparam int N_IN = 20, BIAS_EN = 1, T_STEPS = 8;
  localparam int L1 = N_IN + BIAS_EN;
  localparam int IDX_W = $clog2(N_IN + 1), STEP_W = $clog2(T_STEPS);
  logic clk = 0, reset = 1;
  logic spk_vec_valid = 0, out_ready = 0, clr_overflow = 0;
  logic [N_IN-1:0] spk_vec = '0;
  logic out_valid, out_spk, out_first, out_last, frame_done, busy, overflow;
  logic [IDX_W-1:0] out_idx;
  logic [STEP_W-1:0] step_idx;
  snn_spike_serializer #(.N_IN(N_IN), .BIAS_EN(BIAS_EN), .T_STEPS(T_STEPS)) dut (
    .clk(clk), .reset(reset), .spk_vec_valid(spk_vec_valid), .spk_vec(spk_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_spk(out_spk), .out_idx(out_idx),
    .out_first(out_first), .out_last(out_last), .frame_done(frame_done),
    .step_idx(step_idx), .busy(busy), .overflow(overflow), .clr_overflow(clr_overflow)
  );
  always #5 clk = ~clk;
  typedef struct {logic spk; int idx; int step;} exp_t;
  exp_t sb[$];
  exp_t me;
  int checks = 0, errors = 0;
  int model_slots = 0, frames = 0;
  logic m_ovf = 0;
  bit exp_fd = 0;
  int exp_step = 0;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, req, $time);
    end
  endtask
  // one clock of stimulus; the model tracks outstanding slots and frames, not registers
  task automatic cyc(input bit v, input logic [N_IN-1:0] vec, input bit rdy, input bit clr);
    int rem, outstanding;
    bit xf, drop;
    exp_t e;
    @(negedge clk);
    chk("out_valid", out_valid, model_slots > 0);
    chk("busy", busy, model_slots > 0);
    chk("overflow", overflow, m_ovf);
    spk_vec_valid = v; spk_vec = vec; out_ready = rdy; clr_overflow = clr;
    xf = model_slots > 0 && rdy;
    rem = model_slots % L1;
    if (xf) model_slots--;
    outstanding = (model_slots + L1 - 1) / L1;
    drop = 0;
    if (v) begin
      if (outstanding < 2) begin
        for (int i = 0; i < L1; i++) begin
          e.spk = (i < N_IN) ? vec[i] : 1'b1;
          e.idx = i;
          e.step = (frames + 1) % T_STEPS;
          sb.push_back(e);
        end
        model_slots += L1;
        frames++;
      end else drop = 1;
    end
    m_ovf = (m_ovf & ~clr) | drop;
    if (rem == 0) rem = L1;
  endtask
  initial forever begin
    @(negedge clk);
    #2;
    if (reset) begin
      exp_fd = 0;
    end else begin
      chk("frame_done", frame_done, exp_fd);
      if (exp_fd) chk("step_idx", step_idx, exp_step);
      exp_fd = 0;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_transfer: got idx %0d expected none", out_idx);
        end else begin
          me = sb.pop_front();
          chk("out_idx", out_idx, me.idx);
          chk("out_spk", out_spk, me.spk);
          chk("out_first", out_first, me.idx == 0);
          chk("out_last", out_last, me.idx == L1 - 1);
          if (me.idx == L1 - 1) begin exp_fd = 1; exp_step = me.step; end
        end
      end
    end
  end
  initial begin
    logic [N_IN-1:0] va;
    int pv, pr;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_spk", out_spk, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_first", out_first, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_step_idx", step_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    reset = 0;
    cyc(1, 20'h0000F, 1, 0);
    repeat (25) cyc(0, 0, 1, 0);
    cyc(1, 20'h0000F, 1, 0);
    for (int i = 0; i < 70; i++) cyc(0, 0, (i % 4 == 0) || (i % 4 == 3), 0);
    cyc(1, 20'hA5A5A, 1, 0);
    repeat (3) cyc(0, 0, 1, 0);
    cyc(1, 20'h3C3C3, 1, 0);
    repeat (45) cyc(0, 0, 1, 0);
    cyc(1, 20'h12345, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 20'h54321, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 20'hFFFFF, 0, 0);
    cyc(1, 20'h00001, 0, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    repeat (50) cyc(0, 0, 1, 0);
    cyc(1, 20'h80001, 1, 0);
    repeat (20) cyc(0, 0, 1, 0);
    cyc(1, 20'h7FFFE, 1, 0);
    repeat (25) cyc(0, 0, 1, 0);
    for (int s = 0; s < 15; s++) begin
      pv = $urandom_range(2, 40);
      pr = $urandom_range(20, 100);
      for (int i = 0; i < 200; i++) begin
        va = N_IN'($urandom());
        cyc($urandom_range(0, 99) < pv, va, $urandom_range(0, 99) < pr, $urandom_range(0, 49) == 0);
      end
    end
    repeat (60) cyc(0, 0, 1, 0);
    cyc(1, 20'hFFFFF, 1, 0);
    for (int i = 0; i < 40 && out_idx != 10; i++) cyc(0, 0, 1, 0);
    chk("reach_idx10", out_idx, 10);
    #1 reset = 1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_idx", out_idx, 0);
    chk("mid_rst_out_spk", out_spk, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_step_idx", step_idx, 0);
    sb.delete();
    model_slots = 0; frames = 0; m_ovf = 0;
    spk_vec_valid = 0; out_ready = 1; clr_overflow = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (5) cyc(0, 0, 1, 0);
    chk("post_rst_step_idx", step_idx, 0);
    chk("post_rst_frame_done", frame_done, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/snn_spike_serializer.md
# snn_spike_serializer

Parametrised parallel-to-serial spike bridge between two fully-connected LIF layers. It captures a parallel spike vector from the upstream layer and emits it one spike per transfer on a valid/ready stream, with an optional constant-1 bias slot appended. It also provides a one-deep pending buffer, frame markers, a timestep counter and sticky overflow detection. It replaces the fixed 20+1 counter/mux glue between the FC1 and FC2 layers and supports any layer width.

## Interface
- N_IN, 20, number of parallel spikes per frame (≥1)
- BIAS_EN, 1, 1 = append constant-1 bias slot after the N_IN spikes; 0 = no bias slot
- T_STEPS, 8, number of timesteps per inference; sets step_idx wrap
- IDX_W, $clog2(N_IN+1), width of out_idx
- STEP_W, $clog2(T_STEPS), width of step_idx (min 1)

- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- spk_vec_valid  in  1  single-cycle strobe; spk_vec is valid
- spk_vec  in  N_IN  parallel spikes; bit i = neuron i
- out_valid  out  1  serial spike valid
- out_ready  in  1  downstream accepts
- out_spk  out  1  serial spike (bias slot = 1)
- out_idx  out  IDX_W  slot index of out_spk
- out_first  out  1  high when out_idx==0
- out_last  out  1  high on the final slot, L = N_IN-1+BIAS_EN
- frame_done  out  1  one-cycle pulse after the last-slot transfer
- step_idx  out  STEP_W  count of completed frames, modulo T_STEPS
- busy  out  1  active frame or pending frame held
- overflow  out  1  sticky; a frame was dropped
- clr_overflow  in  1  clears overflow

## Operation
- Storage: active register (ACT) and pending register (PEND), each with a full flag. All outputs are registered.
- States: IDLE (ACT empty) and STREAM (ACT full). busy = ACT.full | PEND.full.
- Transfer: a transfer occurs when out_valid & out_ready. Each transfer increments out_idx. out_spk = ACT[out_idx] for out_idx < N_IN, and 1 for the bias slot.
- Last transfer (out_idx == L):
  - If PEND is full, PEND moves to ACT, out_idx resets to 0 and out_valid stays high, so there is no bubble.
  - Otherwise the block returns to IDLE.
- Capture on spk_vec_valid, resolved after any same-cycle promotion:
  - IDLE → load ACT.
  - STREAM with PEND empty, or PEND being freed this cycle → load PEND.
  - Last transfer with PEND empty → load ACT directly. No bubble.
  - ACT and PEND both full with no freeing transfer → drop the vector and set overflow. ACT and PEND are left unchanged.
- overflow: if set and clear occur in the same cycle, set wins.
- step_idx increments on each last transfer and wraps from T_STEPS-1 to 0.
- out_spk and out_idx hold stable while out_valid=1 and out_ready=0.

## Timing
- Reset values: out_valid=0, out_spk=0, out_idx=0, out_first=0, out_last=0, frame_done=0, step_idx=0, busy=0, overflow=0, ACT/PEND cleared.
- Capture latency: spk_vec_valid in cycle k while IDLE → out_valid=1, out_idx=0 in cycle k+1.
- Frame duration: a frame occupies N_IN+BIAS_EN transfer cycles. With out_ready held high, back-to-back frames stream with zero gap.
- frame_done is asserted in the cycle after the last transfer. step_idx updates in that same cycle.
- Reset mid-frame aborts the stream at once: all state returns to reset values and no frame_done is issued.
- For N_IN=1, BIAS_EN=0, every slot has out_first=out_last=1.

## Test plan
- Single frame: N_IN=20, BIAS_EN=1, spk_vec=0x0000F, out_ready=1 → 21 transfers with out_spk=1 at idx 0-3 and 20, 0 elsewhere. frame_done pulses at cycle k+22. step_idx=1.
- Backpressure: toggle out_ready 1,0,0,1… → out_spk/out_idx stable during stalls. Sequence identical to the single-frame case.
- Back-to-back: vector A at cycle 1, vector B at cycle 5 → 42 consecutive transfers with no out_valid gap. A then B. overflow=0.
- Overflow: vectors at cycles 1, 3 and 5 with out_ready=0 → third vector dropped and overflow=1. Assert clr_overflow with a simultaneous new drop → overflow stays 1.
- Edge capture: spk_vec_valid in the same cycle as the last transfer with PEND empty → next cycle shows out_idx=0 of the new frame. overflow stays 0.
- Wrap and reset: 8 frames with T_STEPS=8 → step_idx returns to 0. Reset asserted at out_idx=10 → all outputs return to reset values next edge and frame_done is not pulsed.
